dispense_sequencer: RTL and testbench
=====================================

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

Interface
REQ-001 Parameter MOTOR_TIMEOUT, default 1000; maximum cycles the motor may run before a jam is declared.
REQ-002 Parameter COIN_TIMEOUT, default 200; maximum cycles allowed for each coin-hopper handshake phase.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse from the vending state machine: purchase accepted.
REQ-006 item_code  input  8  item to dispense; sampled on start.
REQ-007 change_amt  input  4  coins to refund (0-15); sampled on start.
REQ-008 motor_on  output  1  drives the dispense motor.
REQ-009 motor_done  input  1  item-drop sensor; level, already synchronised.
REQ-010 coin_req  output  1  four-phase request to the coin hopper.
REQ-011 coin_ack  input  1  hopper acknowledge.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 coins_paid  output  4  coins released for the current transaction.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 error  output  1  level; high while in ERROR.
REQ-016 err_code  output  2  00 none, 01 motor jam, 10 hopper timeout, 11 reserved.
REQ-017 clear_err  input  1  operator clear; leaves ERROR.

Function
REQ-018 States: IDLE, MOTOR, COIN_REQ, COIN_REL, DONE, ERROR.
REQ-019 IDLE: start=1 latches item_code and change_amt, clears coins_paid and the timer, enters MOTOR next cycle; start is ignored in every other state.
REQ-020 MOTOR: motor_on=1; motor_done=1 -> COIN_REQ if latched change is non-zero, else DONE; timer reaching MOTOR_TIMEOUT with motor_done=0 -> ERROR, err_code=01.
REQ-021 COIN_REQ: coin_req=1 until coin_ack=1, then coins_paid increments and the state becomes COIN_REL; no ack within COIN_TIMEOUT cycles -> ERROR, err_code=10.
REQ-022 COIN_REL: coin_req=0 until coin_ack=0; then COIN_REQ if coins_paid is below the latched change, else DONE; ack stuck high for COIN_TIMEOUT cycles -> ERROR, err_code=10.
REQ-023 A new request never asserts while coin_ack is high; exactly one coin per full handshake.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; coins_paid holds until the next start.
REQ-025 ERROR: motor_on=0 and coin_req=0; coins_paid is frozen; clear_err=1 -> IDLE and err_code=00 next cycle.
REQ-026 Timer resets on every state entry; the count saturates and never wraps.
REQ-027 Simultaneous motor_done and timeout in the same cycle: motor_done wins.
REQ-028 Simultaneous coin_ack and timeout in the same cycle: ack wins.
REQ-029 change_amt=15: exactly 15 handshakes; coins_paid reaches 15 without wrapping.
REQ-030 The dispense latency from start to motor_on is exactly one cycle.

Reset
REQ-031 reset=0 asynchronously forces IDLE, motor_on=0, coin_req=0, busy=0, done=0, error=0, err_code=00, coins_paid=0, latched item and change=0, timer=0.
REQ-032 Reset mid-operation abandons the transaction; no done pulse and no further coin request.

Configuration
REQ-033 Macro DISPENSE_SEQ_RETRY_EN defined: the first motor timeout re-enters MOTOR once with a fresh timer; a second timeout -> ERROR with err_code=01.
REQ-034 DISPENSE_SEQ_RETRY_EN undefined: the first motor timeout -> ERROR immediately, and no retry flag register exists.

Structure
REQ-035 The shared package vend_pkg holds the state enumeration, the err_code constants and the default timeout values.
REQ-036 The single sub-module seq_timer is a saturating counter with clear, enable and a terminal-count flag.

Verification
REQ-037 start, change_amt=3, motor_done after 10 cycles, hopper ack latency 2 -> 3 handshakes, coins_paid=3, one done pulse, busy then low.
REQ-038 start, change_amt=0, motor_done after 5 cycles -> no coin_req ever, done 1 cycle after motor_done.
REQ-039 MOTOR_TIMEOUT=20, motor_done held low -> error=1, err_code=01 at cycle 20 (cycle 40 with DISPENSE_SEQ_RETRY_EN); clear_err -> IDLE.
REQ-040 change_amt=4, hopper never acks the second coin, COIN_TIMEOUT=8 -> ERROR, err_code=10, coins_paid=1.
REQ-041 reset pulsed low during the third coin handshake -> all outputs reset immediately; a following start with change_amt=1 completes normally.
REQ-042 start re-pulsed while busy -> ignored; coins_paid and latched change unchanged.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending dispense path.
// The timeout defaults are also the dispense_sequencer parameter defaults.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOTOR,
        ST_COIN_REQ,
        ST_COIN_REL,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_MOTOR_JAM = 2'b01;
    localparam logic [1:0] ERR_HOPPER_TO = 2'b10;

    localparam int unsigned MOTOR_TIMEOUT_DEF = 1000;
    localparam int unsigned COIN_TIMEOUT_DEF  = 200;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: saturating cycle counter with clear, enable and a
// terminal-count flag that rises on the limit_i-th counted cycle.
module seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count is 0 on the first cycle in a state, so limit_i holds TIMEOUT-1.
    assign tc_o = (cnt_q >= limit_i);

endmodule

// File: rtl/dispense_sequencer.sv
// dispense_sequencer: motor dispense then coin-hopper refund handshakes.
// Define DISPENSE_SEQ_RETRY_EN to retry the motor once after a timeout.
module dispense_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned MOTOR_TIMEOUT = MOTOR_TIMEOUT_DEF,
    parameter int unsigned COIN_TIMEOUT  = COIN_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] item_code,
    input  logic [3:0] change_amt,
    output logic       motor_on,
    input  logic       motor_done,
    output logic       coin_req,
    input  logic       coin_ack,
    output logic       busy,
    output logic [3:0] coins_paid,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    input  logic       clear_err
);

    localparam int unsigned TW =
        $clog2(max_u(MOTOR_TIMEOUT, COIN_TIMEOUT) + 1);
    localparam logic [TW-1:0] M_LIM = TW'(MOTOR_TIMEOUT - 1);
    localparam logic [TW-1:0] C_LIM = TW'(COIN_TIMEOUT - 1);

    seq_state_t state_q, state_d;
    logic [7:0] item_q, item_d;
    logic [3:0] chg_q, chg_d;
    logic [3:0] coins_q, coins_d;
    logic [1:0] err_q, err_d;
    logic       restart;
    logic       tmr_tc;
    logic [TW-1:0] tmr_lim;

`ifdef DISPENSE_SEQ_RETRY_EN
    logic retry_q, retry_d;
`endif

    // Latched item has no consumer on this port list yet.
    logic unused_item;
    assign unused_item = ^item_q;

    assign tmr_lim = (state_q == ST_MOTOR) ? M_LIM : C_LIM;

    seq_timer #(
        .W (TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clr_i   ((state_d != state_q) || restart),
        .en_i    (state_q != ST_IDLE),
        .limit_i (tmr_lim),
        .tc_o    (tmr_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            item_q  <= '0;
            chg_q   <= '0;
            coins_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            item_q  <= item_d;
            chg_q   <= chg_d;
            coins_q <= coins_d;
            err_q   <= err_d;
        end
    end

`ifdef DISPENSE_SEQ_RETRY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retry_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        item_d  = item_q;
        chg_d   = chg_q;
        coins_d = coins_q;
        err_d   = err_q;
        restart = 1'b0;
`ifdef DISPENSE_SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_MOTOR;
                    item_d  = item_code;
                    chg_d   = change_amt;
                    coins_d = '0;
`ifdef DISPENSE_SEQ_RETRY_EN
                    retry_d = 1'b0;
`endif
                end
            end
            ST_MOTOR: begin
                if (motor_done) begin
                    state_d = (chg_q != '0) ? ST_COIN_REQ : ST_DONE;
                end
`ifdef DISPENSE_SEQ_RETRY_EN
                else if (tmr_tc && !retry_q) begin
                    retry_d = 1'b1;
                    restart = 1'b1;
                end
`endif
                else if (tmr_tc) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_MOTOR_JAM;
                end
            end
            ST_COIN_REQ: begin
                if (coin_ack) begin
                    state_d = ST_COIN_REL;
                    coins_d = coins_q + 1'b1;
                end else if (tmr_tc) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_HOPPER_TO;
                end
            end
            ST_COIN_REL: begin
                if (!coin_ack) begin
                    state_d = (coins_q < chg_q) ? ST_COIN_REQ : ST_DONE;
                end else if (tmr_tc) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_HOPPER_TO;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (clear_err) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        motor_on   = (state_q == ST_MOTOR);
        coin_req   = (state_q == ST_COIN_REQ);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        error      = (state_q == ST_ERROR);
        err_code   = err_q;
        coins_paid = coins_q;
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb_dispense_sequencer: directed vectors against a behavioural hopper.
// Define DISPENSE_SEQ_RETRY_EN here too when building the retry variant.
module tb_dispense_sequencer;

    localparam int MT = 20;
    localparam int CT = 8;
`ifdef DISPENSE_SEQ_RETRY_EN
    localparam int MOTOR_RUN = 2 * MT;
`else
    localparam int MOTOR_RUN = MT;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] item_code;
    logic [3:0] change_amt;
    logic       motor_on;
    logic       motor_done;
    logic       coin_req;
    logic       coin_ack = 1'b0;
    logic       busy;
    logic [3:0] coins_paid;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic       clear_err;

    always #5 clk = ~clk;

    dispense_sequencer #(
        .MOTOR_TIMEOUT (MT),
        .COIN_TIMEOUT  (CT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .item_code  (item_code),
        .change_amt (change_amt),
        .motor_on   (motor_on),
        .motor_done (motor_done),
        .coin_req   (coin_req),
        .coin_ack   (coin_ack),
        .busy       (busy),
        .coins_paid (coins_paid),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .clear_err  (clear_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hopper: acks after hop_lat cycles of request, at most hop_max coins.
    logic hop_en = 1'b0;
    int   hop_lat = 1;
    int   hop_max = 0;
    int   hop_given = 0;
    int   hop_age = 0;

    always @(posedge clk) begin
        #2;
        if (!hop_en) begin
            coin_ack  = 1'b0;
            hop_given = 0;
            hop_age   = 0;
        end else if (coin_req && !coin_ack && hop_given < hop_max) begin
            hop_age++;
            if (hop_age >= hop_lat) begin
                coin_ack = 1'b1;
                hop_age  = 0;
                hop_given++;
            end
        end else if (!coin_req) begin
            coin_ack = 1'b0;
        end
    end

    logic mon_clr = 1'b0;
    logic req_prev = 1'b0;
    int   req_rises = 0;
    int   req_run = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (mon_clr) begin
            req_rises = 0;
            req_run   = 0;
            done_cnt  = 0;
        end else begin
            if (coin_req) begin
                if (!req_prev) begin
                    req_rises++;
                    req_run = 1;
                end else begin
                    req_run++;
                end
            end
            if (done) done_cnt++;
        end
        req_prev = coin_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic hop_cfg(input int lat, input int mx);
        hop_en = 1'b0;
        step();
        hop_lat = lat;
        hop_max = mx;
        hop_en  = 1'b1;
    endtask

    task automatic pulse_start(input logic [3:0] chg);
        start      = 1'b1;
        change_amt = chg;
        item_code  = 8'h5A;
        step();
        start      = 1'b0;
    endtask

    task automatic motor_after(input int k);
        steps(k - 1);
        motor_done = 1'b1;
        step();
        motor_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        check_eq(tag, int'(busy), 0);
    endtask

    task automatic wait_err(input string tag, input int bound);
        int n;
        n = 0;
        while (!error && n < bound) begin
            step();
            n++;
        end
        check_eq(tag, int'(error), 1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_motor"}, int'(motor_on), 0);
        check_eq({tag, "_req"}, int'(coin_req), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_error"}, int'(error), 0);
        check_eq({tag, "_ecode"}, int'(err_code), 0);
        check_eq({tag, "_coins"}, int'(coins_paid), 0);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        start      = 1'b0;
        item_code  = 8'h00;
        change_amt = 4'd0;
        motor_done = 1'b0;
        clear_err  = 1'b0;
        #3;
        check_quiet("rst");
        steps(2);
        reset = 1'b1;
        step();

        // Three-coin refund, with a start re-pulse that must be ignored
        hop_cfg(2, 99);
        clr_mon();
        pulse_start(4'd3);
        check_eq("lat_motor", int'(motor_on), 1);
        check_eq("lat_busy", int'(busy), 1);
        start      = 1'b1;
        change_amt = 4'd9;
        step();
        start      = 1'b0;
        check_eq("repulse_motor", int'(motor_on), 1);
        motor_after(8);
        wait_idle("a_idle", 200);
        check_eq("a_coins", int'(coins_paid), 3);
        check_eq("a_reqs", req_rises, 3);
        check_eq("a_dones", done_cnt, 1);

        // Zero change: straight to done
        clr_mon();
        pulse_start(4'd0);
        motor_after(5);
        check_eq("b_done", int'(done), 1);
        step();
        check_eq("b_done_off", int'(done), 0);
        check_eq("b_idle", int'(busy), 0);
        check_eq("b_reqs", req_rises, 0);
        check_eq("b_coins", int'(coins_paid), 0);

        // Motor jam
        pulse_start(4'd2);
        n = 0;
        while (motor_on && n < 100) begin
            n++;
            step();
        end
        check_eq("c_run", n, MOTOR_RUN);
        check_eq("c_error", int'(error), 1);
        check_eq("c_ecode", int'(err_code), 1);
        check_eq("c_req", int'(coin_req), 0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check_eq("c_clr_err", int'(error), 0);
        check_eq("c_clr_code", int'(err_code), 0);
        check_eq("c_clr_busy", int'(busy), 0);

        // motor_done on the timeout cycle wins
        clr_mon();
        pulse_start(4'd0);
        steps(MOTOR_RUN - 1);
        motor_done = 1'b1;
        step();
        motor_done = 1'b0;
        check_eq("g_done", int'(done), 1);
        check_eq("g_error", int'(error), 0);
        step();

        // Hopper stops after the first coin
        hop_cfg(1, 1);
        pulse_start(4'd4);
        motor_after(3);
        wait_err("d_err", 100);
        check_eq("d_ecode", int'(err_code), 2);
        check_eq("d_coins", int'(coins_paid), 1);
        check_eq("d_req", int'(coin_req), 0);
        check_eq("d_req_len", req_run, CT);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check_eq("d_clr_code", int'(err_code), 0);

        // Ack on the last allowed request cycle wins
        hop_cfg(CT, 99);
        clr_mon();
        pulse_start(4'd1);
        motor_after(2);
        wait_idle("h_idle", 100);
        check_eq("h_coins", int'(coins_paid), 1);
        check_eq("h_dones", done_cnt, 1);
        check_eq("h_req_len", req_run, CT);

        // Fifteen coins, no wrap
        hop_cfg(1, 99);
        clr_mon();
        pulse_start(4'd15);
        motor_after(1);
        wait_idle("f_idle", 300);
        check_eq("f_coins", int'(coins_paid), 15);
        check_eq("f_reqs", req_rises, 15);
        check_eq("f_dones", done_cnt, 1);

        // Reset during the third handshake
        hop_cfg(2, 99);
        pulse_start(4'd3);
        motor_after(2);
        n = 0;
        while (!(coins_paid == 4'd2 && coin_req) && n < 200) begin
            step();
            n++;
        end
        check_eq("e_third", int'(coin_req), 1);
        #1;
        reset = 1'b0;
        #1;
        check_quiet("e_rst");
        hop_en = 1'b0;
        steps(2);
        reset = 1'b1;
        clr_mon();
        steps(5);
        check_eq("e_post_reqs", req_rises, 0);
        check_eq("e_post_dones", done_cnt, 0);
        hop_cfg(2, 99);
        clr_mon();
        pulse_start(4'd1);
        motor_after(3);
        wait_idle("e_idle", 100);
        check_eq("e_coins", int'(coins_paid), 1);
        check_eq("e_reqs", req_rises, 1);
        check_eq("e_dones", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
